// File: rtl/pulse_train_gen_pkg.sv
// Shared definitions for the pulse train generator: FSM state encoding and
// default field widths.
package pulse_train_gen_pkg;

  // Default width of the pulse-count field.
  localparam int DEFAULT_COUNT_W = 8;

  // Default width of the high-time and low-time fields.
  localparam int DEFAULT_TIME_W = 8;

  // Train FSM states; o_data is high exactly in ST_HIGH.
  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_HIGH = 2'd1,
    ST_LOW  = 2'd2
  } state_e;

endpackage : pulse_train_gen_pkg

// File: rtl/pulse_timer.sv
// Loadable phase-time down-counter shared by the HIGH and LOW phases.
// A load of zero is clamped to one tick so no phase is ever zero-length.
// o_expire flags the last tick of the current phase.
module pulse_timer
  import pulse_train_gen_pkg::*;
#(
  parameter int TIME_W = DEFAULT_TIME_W
) (
  input  logic              i_clk,
  input  logic              i_reset,
  input  logic              i_ce,
  input  logic              i_load,
  input  logic [TIME_W-1:0] i_load_val,
  input  logic              i_en,
  output logic              o_expire
);

  logic [TIME_W-1:0] cnt_q;
  logic [TIME_W-1:0] cnt_d;

  // Next count: load (clamped) wins over decrement; frozen without a tick.
  always_comb begin
    // NOTE: cnt_d gets its hold value first so every path assigns it and no latch is inferred.
    cnt_d = cnt_q;
    if (i_ce) begin
      if (i_load) begin
        cnt_d = (i_load_val == '0) ? TIME_W'(1) : i_load_val;
      end else if (i_en && (cnt_q != '0)) begin
        // Saturates at zero rather than wrapping.
        cnt_d = cnt_q - TIME_W'(1);
      end
    end
  end

  // Count register with asynchronous reset.
  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      // NOTE: non-blocking assignments keep every flop sampling pre-edge values.
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  // The phase ends on the tick taken while one tick remains.
  assign o_expire = (cnt_q == TIME_W'(1));

endmodule : pulse_timer

// File: rtl/pulse_train_gen.sv
// Pulse train generator: on start emits i_count pulses, each max(i_high,1)
// ticks high followed by max(i_low,1) ticks low, then strobes o_done.
// Abort and reset truncate the train silently. All outputs are registered.
module pulse_train_gen
  import pulse_train_gen_pkg::*;
#(
  parameter int COUNT_W = DEFAULT_COUNT_W,
  parameter int TIME_W  = DEFAULT_TIME_W
) (
  input  logic               i_clk,
  input  logic               i_reset,
  input  logic               i_ce,
  input  logic               i_start,
  input  logic               i_abort,
  input  logic [COUNT_W-1:0] i_count,
  input  logic [TIME_W-1:0]  i_high,
  input  logic [TIME_W-1:0]  i_low,
  output logic               o_data,
  output logic               o_busy,
  output logic               o_done
);

  state_e             state_q, state_d;
  logic [COUNT_W-1:0] remaining_q, remaining_d;
  logic [TIME_W-1:0]  high_q, high_d;
  logic [TIME_W-1:0]  low_q, low_d;
  logic               data_q, data_d;
  logic               busy_q, busy_d;
  logic               done_q, done_d;

  logic               tmr_load;
  logic [TIME_W-1:0]  tmr_val;
  logic               tmr_en;
  logic               tmr_expire;

  // One timer serves both phases; it is reloaded on every phase entry.
  pulse_timer #(
    .TIME_W (TIME_W)
  ) u_timer (
    .i_clk      (i_clk),
    .i_reset    (i_reset),
    .i_ce       (i_ce),
    .i_load     (tmr_load),
    .i_load_val (tmr_val),
    .i_en       (tmr_en),
    .o_expire   (tmr_expire)
  );

  // Next-state, latch and timer-control logic; everything advances on ticks only.
  always_comb begin
    state_d     = state_q;
    remaining_d = remaining_q;
    high_d      = high_q;
    low_d       = low_q;
    done_d      = 1'b0;   // strobe lasts one i_clk cycle, tick or not
    tmr_load    = 1'b0;
    tmr_val     = high_q;
    tmr_en      = 1'b0;

    if (i_ce) begin
      unique case (state_q)
        ST_IDLE: begin
          // Abort outranks start; in IDLE it simply suppresses the start.
          if (i_start && !i_abort) begin
            if (i_count != '0) begin
              state_d     = ST_HIGH;
              remaining_d = i_count;
              high_d      = i_high;
              low_d       = i_low;
              tmr_load    = 1'b1;
              tmr_val     = i_high;
            end else begin
              // Empty train: complete immediately without a pulse.
              done_d = 1'b1;
            end
          end
        end

        ST_HIGH: begin
          if (i_abort) begin
            state_d     = ST_IDLE;
            remaining_d = '0;
          end else if (tmr_expire) begin
            state_d  = ST_LOW;
            tmr_load = 1'b1;
            tmr_val  = low_q;
          end else begin
            tmr_en = 1'b1;
          end
        end

        ST_LOW: begin
          if (i_abort) begin
            state_d     = ST_IDLE;
            remaining_d = '0;
          end else if (tmr_expire) begin
            if (remaining_q > COUNT_W'(1)) begin
              state_d     = ST_HIGH;
              remaining_d = remaining_q - COUNT_W'(1);
              tmr_load    = 1'b1;
              tmr_val     = high_q;
            end else begin
              state_d     = ST_IDLE;
              remaining_d = '0;
              done_d      = 1'b1;
            end
          end else begin
            tmr_en = 1'b1;
          end
        end

        default: begin
          state_d     = ST_IDLE;
          remaining_d = '0;
        end
      endcase
    end

    // Outputs are registered copies of the decoded next state.
    data_d = (state_d == ST_HIGH);
    busy_d = (state_d != ST_IDLE);
  end

  // State, latches and output registers, all cleared asynchronously.
  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      state_q     <= ST_IDLE;
      remaining_q <= '0;
      high_q      <= '0;
      low_q       <= '0;
      data_q      <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      remaining_q <= remaining_d;
      high_q      <= high_d;
      low_q       <= low_d;
      data_q      <= data_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
    end
  end

  assign o_data = data_q;
  assign o_busy = busy_q;
  assign o_done = done_q;

endmodule : pulse_train_gen

// File: tb/tb_pulse_train_gen.sv
// Self-checking bench for pulse_train_gen: a directed vector table, hand
// sequences for abort and asynchronous reset, and randomized trains checked
// against a waveform model built from the high/low/count rules.
module tb_pulse_train_gen;

  logic       i_clk = 1'b0;
  logic       i_reset;
  logic       i_ce;
  logic       i_start;
  logic       i_abort;
  logic [7:0] i_count;
  logic [7:0] i_high;
  logic [7:0] i_low;
  logic       o_data;
  logic       o_busy;
  logic       o_done;

  int n_pass  = 0;
  int n_total = 0;

  // Expected o_data per tick since start, built by build_pattern().
  bit pat[$];

  typedef struct packed {
    logic       ce;
    logic       start;
    logic       abort;
    logic [7:0] count;
    logic [7:0] high;
    logic [7:0] low;
    logic       exp_data;
    logic       exp_busy;
    logic       exp_done;
  } vec_t;

  vec_t vecs[$];

  pulse_train_gen dut (
    .i_clk   (i_clk),
    .i_reset (i_reset),
    .i_ce    (i_ce),
    .i_start (i_start),
    .i_abort (i_abort),
    .i_count (i_count),
    .i_high  (i_high),
    .i_low   (i_low),
    .o_data  (o_data),
    .o_busy  (o_busy),
    .o_done  (o_done)
  );

  always #5 i_clk = ~i_clk;

  task automatic check(input string name, input int unsigned act, input int unsigned exp);
    n_total++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
  endtask

  function automatic vec_t v(input logic ce, start, abort, input logic [7:0] c, h, l,
                             input logic d, b, dn);
    vec_t r;
    r.ce = ce; r.start = start; r.abort = abort;
    r.count = c; r.high = h; r.low = l;
    r.exp_data = d; r.exp_busy = b; r.exp_done = dn;
    return r;
  endfunction

  // Reference waveform: count pulses of max(h,1) ones then max(l,1) zeros.
  task automatic build_pattern(input int c, input int h, input int l);
    int eh, el;
    eh = (h == 0) ? 1 : h;
    el = (l == 0) ? 1 : l;
    pat.delete();
    for (int p = 0; p < c; p++) begin
      for (int i = 0; i < eh; i++) pat.push_back(1'b1);
      for (int i = 0; i < el; i++) pat.push_back(1'b0);
    end
  endtask

  // Drive inputs, take one clock edge, settle past the edge.
  task automatic step(input logic ce, start, abort, input logic [7:0] c, h, l);
    i_ce = ce; i_start = start; i_abort = abort;
    i_count = c; i_high = h; i_low = l;
    @(posedge i_clk);
    #1;
  endtask

  // Start a train on a tick, then follow it cycle by cycle against the model.
  // ce_mode: 0 = always 1, 1 = alternating 0/1, 2 = random.
  // Spurious starts with other parameters are injected while busy.
  task automatic run_train(input int c, input int h, input int l, input int ce_mode);
    int  n, k, cyc, tail, rises, dones;
    bit  reached, prev, ce;
    bit  exp_d, exp_b;
    build_pattern(c, h, l);
    n = pat.size();
    step(1'b1, 1'b1, 1'b0, 8'(c), 8'(h), 8'(l));
    k = 0;
    reached = (n == 0);
    exp_d = (n > 0) ? pat[0] : 1'b0;
    exp_b = (n > 0);
    check("train_start", {o_data, o_busy, o_done}, {exp_d, exp_b, reached});
    rises = int'(o_data);
    dones = int'(o_done);
    prev  = o_data;
    tail  = 0;
    for (cyc = 1; cyc < 400 && tail < 3; cyc++) begin
      case (ce_mode)
        0:       ce = 1'b1;
        1:       ce = cyc[0] ? 1'b0 : 1'b1;
        default: ce = 1'($urandom_range(0, 1));
      endcase
      if (k < n && ($urandom_range(0, 3) == 0))
        step(ce, 1'b1, 1'b0, 8'($urandom_range(1, 9)), 8'($urandom_range(0, 9)),
             8'($urandom_range(0, 9)));
      else
        step(ce, 1'b0, 1'b0, 8'd0, 8'd0, 8'd0);
      if (ce && k < n) begin
        k++;
        reached = (k == n);
      end else begin
        reached = 1'b0;
      end
      exp_d = (k < n) ? pat[k] : 1'b0;
      exp_b = (k < n);
      check("train_cycle", {o_data, o_busy, o_done}, {exp_d, exp_b, reached});
      if (o_data && !prev) rises++;
      if (o_done) dones++;
      prev = o_data;
      if (k == n) tail++;
    end
    check("train_complete", k, n);
    check("train_rising_edges", rises, c);
    check("train_done_cycles", dones, 1);
  endtask

  initial begin
    int rises, dones;

    i_reset = 1'b1;
    i_ce = 1'b0; i_start = 1'b0; i_abort = 1'b0;
    i_count = '0; i_high = '0; i_low = '0;

    // Reset state.
    #1;
    check("reset_data", o_data, 0);
    check("reset_busy", o_busy, 0);
    check("reset_done", o_done, 0);
    i_ce = 1'b1; i_start = 1'b1; i_count = 8'd3;
    repeat (2) @(posedge i_clk);
    #1;
    check("reset_hold", {o_data, o_busy, o_done}, 0);
    i_start = 1'b0;
    #2 i_reset = 1'b0;

    // Directed vectors: 3x(2 high,1 low), empty train, start+abort in idle,
    // zero times clamped to one tick, start without a tick.
    vecs.push_back(v(1, 1, 0, 3, 2, 1, 1, 1, 0));
    vecs.push_back(v(1, 0, 0, 0, 0, 0, 1, 1, 0));
    vecs.push_back(v(1, 0, 0, 0, 0, 0, 0, 1, 0));
    vecs.push_back(v(1, 1, 0, 7, 7, 7, 1, 1, 0));  // start while busy: ignored
    vecs.push_back(v(1, 0, 0, 0, 0, 0, 1, 1, 0));
    vecs.push_back(v(1, 0, 0, 0, 0, 0, 0, 1, 0));
    vecs.push_back(v(1, 0, 0, 0, 0, 0, 1, 1, 0));
    vecs.push_back(v(1, 0, 0, 0, 0, 0, 1, 1, 0));
    vecs.push_back(v(1, 0, 0, 0, 0, 0, 0, 1, 0));
    vecs.push_back(v(1, 0, 0, 0, 0, 0, 0, 0, 1));
    vecs.push_back(v(1, 0, 0, 0, 0, 0, 0, 0, 0));
    vecs.push_back(v(1, 1, 0, 0, 4, 4, 0, 0, 1));
    vecs.push_back(v(1, 0, 0, 0, 0, 0, 0, 0, 0));
    vecs.push_back(v(1, 1, 1, 3, 2, 1, 0, 0, 0));
    vecs.push_back(v(1, 0, 0, 0, 0, 0, 0, 0, 0));
    vecs.push_back(v(1, 1, 0, 2, 0, 0, 1, 1, 0));
    vecs.push_back(v(1, 0, 0, 0, 0, 0, 0, 1, 0));
    vecs.push_back(v(1, 0, 0, 0, 0, 0, 1, 1, 0));
    vecs.push_back(v(1, 0, 0, 0, 0, 0, 0, 1, 0));
    vecs.push_back(v(1, 0, 0, 0, 0, 0, 0, 0, 1));
    vecs.push_back(v(1, 0, 0, 0, 0, 0, 0, 0, 0));
    vecs.push_back(v(0, 1, 0, 1, 1, 1, 0, 0, 0));
    vecs.push_back(v(0, 0, 0, 0, 0, 0, 0, 0, 0));
    foreach (vecs[i]) begin
      step(vecs[i].ce, vecs[i].start, vecs[i].abort,
           vecs[i].count, vecs[i].high, vecs[i].low);
      check($sformatf("vec%0d", i), {o_data, o_busy, o_done},
            {vecs[i].exp_data, vecs[i].exp_busy, vecs[i].exp_done});
    end

    // Clock-enable toggling: each 2-tick phase spans 4 clock cycles.
    run_train(1, 2, 2, 1);

    // Abort during the second HIGH phase of a 5x(3,3) train.
    build_pattern(5, 3, 3);
    step(1'b1, 1'b1, 1'b0, 8'd5, 8'd3, 8'd3);
    check("abort_seq_k0", o_data, pat[0]);
    rises = int'(o_data);
    for (int k = 1; k <= 6; k++) begin
      step(1'b1, 1'b0, 1'b0, 8'd0, 8'd0, 8'd0);
      check($sformatf("abort_seq_k%0d", k), o_data, pat[k]);
      if (o_data && !pat[k-1]) rises++;
    end
    step(1'b1, 1'b0, 1'b1, 8'd0, 8'd0, 8'd0);
    check("abort_outputs", {o_data, o_busy, o_done}, 3'b000);
    dones = 0;
    for (int k = 0; k < 8; k++) begin
      step(1'($urandom_range(0, 1)), 1'b0, 1'b0, 8'd0, 8'd0, 8'd0);
      if (o_done) dones++;
      if (o_data) rises++;  // any high here would be a new pulse
    end
    check("abort_no_done", dones, 0);
    check("abort_rising_edges", rises, 2);

    // Asynchronous reset in the LOW phase of a 4-pulse train.
    step(1'b1, 1'b1, 1'b0, 8'd4, 8'd2, 8'd3);
    step(1'b1, 1'b0, 1'b0, 8'd0, 8'd0, 8'd0);
    step(1'b1, 1'b0, 1'b0, 8'd0, 8'd0, 8'd0);
    check("pre_reset_low", {o_data, o_busy}, 2'b01);
    #2 i_reset = 1'b1;
    #1;
    check("async_reset_outputs", {o_data, o_busy, o_done}, 3'b000);
    @(posedge i_clk);
    #3 i_reset = 1'b0;
    // Start on the very first tick after release; must be a full train.
    run_train(4, 2, 3, 0);

    // Randomized trains with random clock enable.
    for (int t = 0; t < 30; t++) begin
      run_train($urandom_range(0, 4), $urandom_range(0, 3), $urandom_range(0, 3), 2);
      repeat ($urandom_range(0, 2)) begin
        step(1'($urandom_range(0, 1)), 1'b0, 1'b0, 8'd0, 8'd0, 8'd0);
        check("idle_gap", {o_data, o_busy, o_done}, 3'b000);
      end
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule : tb_pulse_train_gen
